fetch_unit: RTL and testbench



---
 rtl/core_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants for the instruction fetch front end
// Ports: none (package).
package core_pkg;
   localparam int INST_W  = 32;
   localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with registered head read data
// Ports: clk, reset (async, active-high); push/push_data append at the tail;
// pop removes the head; flush empties the FIFO and wins over push;
// head_data is the registered head entry; count is the occupancy 0..DEPTH.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr_next;
   logic             do_push;
   logic             do_pop;

   assign do_pop      = pop && (count != '0);
   assign do_push     = push && (count != CW'(DEPTH));
   assign rd_ptr_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         head_data <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr_next;
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
         // An entry written this cycle is not in mem yet; bypass it when it becomes the head.
         if (do_push && (rd_ptr_next == wr_ptr)) begin
            head_data <= push_data;
         end else begin
            head_data <= mem[rd_ptr_next];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch stage with instruction queue
// Ports: clk, reset (async, active-high);
// imem_req_valid/ready/addr issue word-aligned fetch requests;
// imem_rsp_valid/data return instructions in order without backpressure;
// redirect_valid/redirect_pc flush the queue and restart fetch;
// inst_valid/ready/data/pc present the queue head to decode.
module fetch_unit
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [XLEN-1:0]   inst_pc
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   pending;
   logic [CW-1:0]   stale;
   logic [CW-1:0]   count;
   logic [CW:0]     used;
   logic            req_fire;
   logic            rsp_live;
   logic            pop_fire;
   logic [XLEN-1:0] live_pc;
   entry_t          push_entry;
   entry_t          head_entry;

   // Every live request owns a queue slot, so a response always finds room.
   assign used           = {1'b0, count} + {1'b0, pending};
   assign imem_req_valid = !redirect_valid && (used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_live       = imem_rsp_valid && (stale == '0);
   assign pop_fire       = inst_valid && inst_ready;

   // Live requests are the most recent ones, so the oldest sits pending words behind fetch_pc.
   assign live_pc = fetch_pc - (XLEN'(pending) * XLEN'(PC_STEP));

   assign push_entry.pc   = live_pc;
   assign push_entry.inst = imem_rsp_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         pending  <= '0;
         stale    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
         pending  <= '0;
         // A response in this cycle retires one of the requests being orphaned.
         stale    <= stale + pending - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
         end
         pending <= pending + CW'(req_fire) - CW'(rsp_live);
         if (imem_rsp_valid && (stale != '0)) begin
            stale <= stale - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rsp_live),
      .push_data (push_entry),
      .pop       (pop_fire),
      .flush     (redirect_valid),
      .head_data (head_entry),
      .count     (count)
   );

   assign inst_valid = (count != '0);
   assign inst_data  = head_entry.inst;
   assign inst_pc    = head_entry.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   mreq_t       mq[$];
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          issued = 0;
   logic [31:0] exp_fetch = 32'h0;

   fetch_unit #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // One clock cycle: score handshakes at the negedge, then let the memory model drive the next response.
   task automatic tick();
      exp_t  e;
      mreq_t m;
      @(negedge clk);
      if (reset) begin
         mq.delete();
         sb.delete();
         exp_fetch = 32'h0;
      end else begin
         if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_pop", {31'b0, inst_valid}, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("pop_pc", inst_pc, e.pc);
               chk("pop_data", inst_data, e.data);
            end
         end
         if (redirect_valid) begin
            sb.delete();
            exp_fetch = redirect_pc & ~32'h3;
            chk("req_in_redirect", {31'b0, imem_req_valid}, 32'h0);
         end
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_fetch);
            m.due  = cyc + lat;
            m.addr = imem_req_addr;
            mq.push_back(m);
            e.pc   = exp_fetch;
            e.data = mem_word(exp_fetch);
            sb.push_back(e);
            exp_fetch = exp_fetch + 32'h4;
            issued++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
         m = mq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(m.addr);
      end
   endtask

   task automatic wait_valid(input int max_cycles, input string tag);
      for (int i = 0; i < max_cycles; i++) begin
         if (inst_valid) break;
         tick();
      end
      chk(tag, {31'b0, inst_valid}, 32'h1);
   endtask

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;

      tick();
      tick();
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);

      // Streaming with single-cycle memory
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      tick();
      chk("lat_t1_empty", {31'b0, inst_valid}, 32'h0);
      tick();
      chk("lat_t2_valid", {31'b0, inst_valid}, 32'h1);
      chk("lat_t2_pc", inst_pc, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("stream_valid", {31'b0, inst_valid}, 32'h1);
         chk("stream_pc", inst_pc, 32'(k * 4));
      end

      // Backpressure fills exactly DEPTH slots
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      inst_ready     = 1'b0;
      tick();
      redirect_valid = 1'b0;
      issued         = 0;
      repeat (10) tick();
      chk("bp_issued", 32'(issued), 32'd4);
      chk("bp_req_stalled", {31'b0, imem_req_valid}, 32'h0);
      chk("bp_head_pc", inst_pc, 32'h40);
      inst_ready = 1'b1;
      tick();
      chk("bp_resume_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("bp_resume_addr", imem_req_addr, 32'h50);
      repeat (3) tick();
      chk("bp_after_drain_pc", inst_pc, 32'h50);

      // Redirect with three requests in flight at latency 3
      imem_req_ready = 1'b0;
      repeat (6) tick();
      chk("drained", {31'b0, inst_valid}, 32'h0);
      lat            = 3;
      imem_req_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      wait_valid(15, "redir_wait");
      chk("redir_first_pc", inst_pc, 32'h100);
      chk("redir_first_data", inst_data, mem_word(32'h100));

      // Redirect coinciding with response and pop, target at top of address space
      lat = 1;
      repeat (8) tick();
      #1;
      chk("pre_redir_valid", {31'b0, inst_valid}, 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("flush_empty", {31'b0, inst_valid}, 32'h0);
      #1;
      chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr1", imem_req_addr, 32'h0);
      wait_valid(10, "wrap_wait");
      chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc1", inst_pc, 32'h0);

      // Back-to-back redirects, last one wins and low bits are ignored
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("b2b_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("b2b_addr", imem_req_addr, 32'h100);
      wait_valid(10, "b2b_wait");
      chk("b2b_pc", inst_pc, 32'h100);

      // Reset with the queue full
      inst_ready = 1'b0;
      repeat (12) tick();
      chk("full_valid", {31'b0, inst_valid}, 32'h1);
      chk("full_stalled", {31'b0, imem_req_valid}, 32'h0);
      reset = 1'b1;
      #1;
      chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("mid_rst_inst_data", inst_data, 32'h0);
      chk("mid_rst_inst_pc", inst_pc, 32'h0);
      chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("mid_rst_req_addr", imem_req_addr, 32'h0);
      tick();
      reset      = 1'b0;
      inst_ready = 1'b1;
      wait_valid(10, "restart_wait");
      chk("restart_pc", inst_pc, 32'h0);
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
